cpu_bus_master: RTL and testbench

//  Parametrised CPU-side master for the C1/A1/D1 CPU<->cache bus. Accepts requests from a

---
 rtl/cpu_bus_master.sv | 185 ++++++++++++++++++
 tb/tb_cpu_bus_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_master.sv
// CPU-side master for the C1/A1/D1 bus: queues core requests in a FIFO
// and runs each one as address phase, released-bus wait, data capture.
module cpu_bus_master #(
    parameter int CPU_ADDR_W = 19,
    parameter int OFFSET_W   = 4,
    parameter int BUS_D_W    = 16,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [2:0]                       req_cmd,
    input  logic [CPU_ADDR_W-1:0]            req_addr,
    input  logic [2*BUS_D_W-1:0]             req_wdata,
    output logic                             resp_valid,
    output logic [2*BUS_D_W-1:0]             resp_rdata,
    output logic                             resp_err,
    inout  wire  [2:0]                       C1,
    output wire  [CPU_ADDR_W-OFFSET_W-1:0]   A1,
    inout  wire  [BUS_D_W-1:0]               D1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int AW = CPU_ADDR_W - OFFSET_W;
    localparam int DW = 2 * BUS_D_W;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_RD8  = 3'd1;
    localparam logic [2:0] C_RD16 = 3'd2;
    localparam logic [2:0] C_RD32 = 3'd3;
    localparam logic [2:0] C_WR32 = 3'd7;
    localparam logic [2:0] C_RESP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR1, S_ADDR2, S_WAIT, S_RESP1, S_RESP2, S_TURN
    } state_t;

    logic [2:0]            cmd_mem_q  [DEPTH];
    logic [CPU_ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0]         data_mem_q [DEPTH];

    logic [PW:0]           wr_ptr_q, rd_ptr_q;
    logic                  full, empty, push;
    logic [2:0]            head_cmd;
    logic [CPU_ADDR_W-1:0] head_addr;
    logic [DW-1:0]         head_data;

    state_t                state_q;
    logic [2:0]            cmd_q;
    logic [CPU_ADDR_W-1:0] addr_q;
    logic [DW-1:0]         wdata_q;
    logic [BUS_D_W-1:0]    lo_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  c1_oe_q, a1_oe_q, d1_oe_q;
    logic [2:0]            c1_q;
    logic [AW-1:0]         a1_q;
    logic [BUS_D_W-1:0]    d1_q;
    logic                  resp_valid_q, resp_err_q;
    logic [DW-1:0]         resp_rdata_q;
    logic [DW-1:0]         rd_word;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head_cmd  = cmd_mem_q[rd_ptr_q[PW-1:0]];
    assign head_addr = addr_mem_q[rd_ptr_q[PW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[PW-1:0]];
    assign cnt_d     = cnt_q + 1'b1;

    assign C1 = c1_oe_q ? c1_q : 3'bz;
    assign A1 = a1_oe_q ? a1_q : {AW{1'bz}};
    assign D1 = d1_oe_q ? d1_q : {BUS_D_W{1'bz}};

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        rd_word = '0;
        if (cmd_q == C_RD8)
            rd_word[7:0] = D1[7:0];
        else if (cmd_q == C_RD16)
            rd_word[BUS_D_W-1:0] = D1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem_q[wr_ptr_q[PW-1:0]]  <= req_cmd;
            addr_mem_q[wr_ptr_q[PW-1:0]] <= req_addr;
            data_mem_q[wr_ptr_q[PW-1:0]] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            cnt_q        <= '0;
            c1_oe_q      <= 1'b1;
            c1_q         <= C_NOP;
            a1_oe_q      <= 1'b0;
            a1_q         <= '0;
            d1_oe_q      <= 1'b0;
            d1_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            unique case (state_q)
                S_IDLE: if (!empty) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    cmd_q    <= head_cmd;
                    addr_q   <= head_addr;
                    wdata_q  <= head_data;
                    c1_q     <= head_cmd;
                    a1_oe_q  <= 1'b1;
                    a1_q     <= head_addr[CPU_ADDR_W-1:OFFSET_W];
                    d1_oe_q  <= head_cmd[2] && (head_cmd[1:0] != 2'b00);
                    d1_q     <= head_data[BUS_D_W-1:0];
                    state_q  <= S_ADDR1;
                end
                S_ADDR1: begin
                    a1_q    <= {{(AW-OFFSET_W){1'b0}}, addr_q[OFFSET_W-1:0]};
                    d1_oe_q <= cmd_q == C_WR32;
                    d1_q    <= wdata_q[DW-1:BUS_D_W];
                    state_q <= S_ADDR2;
                end
                S_ADDR2: begin
                    c1_oe_q <= 1'b0;
                    a1_oe_q <= 1'b0;
                    d1_oe_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (C1 == C_RESP) begin
                        state_q <= S_RESP1;
                        lo_q    <= D1;
                        if (cmd_q != C_RD32) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= rd_word;
                        end
                    end else if (cnt_d == CW'(TIMEOUT)) begin
                        state_q      <= S_TURN;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                    end
                end
                S_RESP1: begin
                    if (cmd_q == C_RD32) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= {D1, lo_q};
                        state_q      <= S_RESP2;
                    end else begin
                        state_q <= S_TURN;
                    end
                end
                S_RESP2: state_q <= S_TURN;
                S_TURN: begin
                    c1_oe_q <= 1'b1;
                    c1_q    <= C_NOP;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomized bench for cpu_bus_master with a transaction-level cache
// responder and a scoreboard of expected bus phases and responses.
module tb_cpu_bus_master;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1023;

    typedef struct {
        logic [2:0]  cmd;
        logic [18:0] addr;
        logic [31:0] wdata;
        int          k;
        logic [15:0] lo;
        logic [15:0] hi;
    } req_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    wire  [2:0]  c1_w;
    wire  [14:0] a1_w;
    wire  [15:0] d1_w;
    logic        cache_oe = 0;
    logic [15:0] cache_d = 0;
    req_t        in_req;

    assign c1_w = cache_oe ? 3'd7 : 3'bz;
    assign d1_w = cache_oe ? cache_d : 16'bz;

    cpu_bus_master dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (in_req.cmd),
        .req_addr  (in_req.addr),
        .req_wdata (in_req.wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .C1        (c1_w),
        .A1        (a1_w),
        .D1        (d1_w)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   s = 0, exp_r = 0, idle_cyc = 0, rel_cyc = 0;
    bit   active = 0;
    bit   last_acc = 0;
    bit   ready_prev = 0;
    req_t cur;
    req_t fifo_m[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input req_t r);
        if (r.k == 0) return 32'd0;
        case (r.cmd)
            3'd1:    return {24'd0, r.lo[7:0]};
            3'd2:    return {16'd0, r.lo};
            3'd3:    return {r.hi, r.lo};
            default: return 32'd0;
        endcase
    endfunction

    task automatic monitor();
        bit due;
        due = active && (cyc == exp_r);
        if (active && cyc == s) begin
            check("addr1_c1", c1_w, cur.cmd);
            check("addr1_a1", a1_w, cur.addr[18:4]);
            if (cur.cmd >= 3'd5)
                check("addr1_d1", d1_w, cur.wdata[15:0]);
        end
        if (active && cyc == s + 1) begin
            check("addr2_c1", c1_w, cur.cmd);
            check("addr2_a1", a1_w, {11'd0, cur.addr[3:0]});
            if (cur.cmd == 3'd7)
                check("addr2_d1", d1_w, cur.wdata[31:16]);
        end
        if (active && cyc == s + 2)
            check("wait_released",
                  {dut.c1_oe_q, dut.a1_oe_q, dut.d1_oe_q}, 0);
        if (resp_valid || due) begin
            check("resp_valid", resp_valid, due);
            if (due) begin
                check("resp_rdata", resp_rdata, exp_rdata(cur));
                check("resp_err", resp_err, cur.k == 0);
                active = 0;
                idle_cyc = cyc + ((cur.k == 0) ? 1 : 2);
            end
        end
        if (!active && cyc == idle_cyc)
            check("idle_nop", {dut.c1_oe_q, c1_w}, 4'b1000);
        if (cache_oe && cyc == rel_cyc)
            cache_oe = 0;
        if (active && cur.k != 0) begin
            if (cyc == s + 1 + cur.k) begin
                cache_oe = 1;
                cache_d  = cur.lo;
                rel_cyc  = s + 2 + cur.k + ((cur.cmd == 3'd3) ? 1 : 0);
            end else if (cur.cmd == 3'd3 && cyc == s + 2 + cur.k) begin
                cache_d = cur.hi;
            end
        end
    endtask

    task automatic tick();
        bit acc, r;
        acc = req_valid && ready_prev && !reset;
        r = reset;
        @(negedge clk);
        cyc++;
        last_acc = acc;
        if (r) begin
            fifo_m.delete();
            active = 0;
            cache_oe = 0;
            idle_cyc = cyc;
            if (resp_valid)
                check("resp_in_reset", resp_valid, 0);
        end else begin
            if (acc) fifo_m.push_back(in_req);
            monitor();
        end
        check("req_ready", req_ready, fifo_m.size() < DEPTH);
        ready_prev = req_ready;
        if (!active && cyc >= idle_cyc && fifo_m.size() > 0) begin
            cur = fifo_m.pop_front();
            active = 1;
            s = cyc + 1;
            if (cur.k == 0)
                exp_r = s + 2 + TIMEOUT;
            else
                exp_r = s + 2 + cur.k + ((cur.cmd == 3'd3) ? 1 : 0);
        end
    endtask

    task automatic push(input req_t r);
        int n;
        n = 0;
        in_req = r;
        req_valid = 1;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 3000);
        if (!last_acc) check("push_timeout", 0, 1);
        req_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((active || fifo_m.size() > 0 || cyc < idle_cyc + 1)
               && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) check("drain_timeout", 0, 1);
    endtask

    function automatic req_t mk(input logic [2:0] c, input logic [18:0] a,
                                input logic [31:0] w, input int k,
                                input logic [15:0] lo,
                                input logic [15:0] hi);
        req_t r;
        r.cmd = c; r.addr = a; r.wdata = w;
        r.k = k; r.lo = lo; r.hi = hi;
        return r;
    endfunction

    initial begin
        req_t r;
        int n;
        in_req = mk(3'd0, 0, 0, 1, 0, 0);

        reset = 1;
        repeat (3) tick();
        check("rst_c1", {dut.c1_oe_q, c1_w}, 4'b1000);
        check("rst_a1_z", dut.a1_oe_q, 0);
        check("rst_d1_z", dut.d1_oe_q, 0);
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        reset = 0;
        tick();

        push(mk(3'd1, 19'h00035, 0, 2, 16'h12AB, 0));
        drain();
        push(mk(3'd7, 19'h1A2B4, 32'hDEADBEEF, 1, 16'h5555, 0));
        drain();
        push(mk(3'd3, 19'h7FFFF, 0, 3, 16'h5678, 16'h1234));
        drain();

        for (int i = 0; i < 40; i++) begin
            r = mk(3'($urandom_range(1, 7)), 19'($urandom), $urandom,
                   int'($urandom_range(1, 4)), 16'($urandom),
                   16'($urandom));
            push(r);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();

        for (int i = 0; i < 5; i++)
            push(mk(3'($urandom_range(1, 7)), 19'($urandom), $urandom,
                    0, 0, 0));
        check("full_ready", req_ready, 0);
        in_req = mk(3'd2, 19'h12345, 0, 1, 0, 0);
        req_valid = 1;
        tick();
        check("full_refused", last_acc, 0);
        req_valid = 0;
        drain();

        push(mk(3'd2, 19'h0ABCD, 0, 0, 0, 0));
        push(mk(3'd1, 19'h00100, 0, 1, 16'h00FF, 0));
        push(mk(3'd6, 19'h00200, 32'h1111, 1, 0, 0));
        n = 0;
        while (!(active && cyc == s + 4) && n < 100) begin
            tick();
            n++;
        end
        check("reached_wait", active && cyc == s + 4, 1);
        reset = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        check("post_rst_ready", req_ready, 1);
        check("post_rst_c1", {dut.c1_oe_q, c1_w}, 4'b1000);
        repeat (40) tick();
        check("post_rst_idle", {dut.c1_oe_q, c1_w}, 4'b1000);
        check("post_rst_empty", fifo_m.size() + active, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
